// File: rtl/wb_pkg.sv
// Shared Wishbone-classic definitions: bus widths, initiator state encoding and
// helpers used by initiator and future slave blocks.
package wb_pkg;

    localparam int unsigned WB_ADR_W = 30;
    localparam int unsigned WB_DAT_W = 32;
    localparam int unsigned WB_SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } wb_init_state_e;

    localparam logic [WB_DAT_W-1:0] WB_ERR_DATA = 32'h0;

    // Counter width able to hold TIMEOUT, never narrower than one bit.
    function automatic int unsigned wb_cnt_width(input int unsigned timeout);
        int unsigned w;
        w = $clog2(timeout + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/wb_timeout.sv
// Saturating cycle counter with synchronous clear and count enable; flags
// expiry on the last of TIMEOUT counted cycles. TIMEOUT=0 never expires.
module wb_timeout
    import wb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = wb_cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expired_o = (TIMEOUT != 0) && (cnt_q == LAST);

endmodule

// File: rtl/wb_initiator.sv
// Wishbone-classic bus master: one bus cycle per command from a valid/ready
// request channel, result returned on a valid/ready response channel.
module wb_initiator
    import wb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_we_i,
    input  logic [WB_ADR_W-1:0] req_adr_i,
    input  logic [WB_SEL_W-1:0] req_sel_i,
    input  logic [WB_DAT_W-1:0] req_dat_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [WB_DAT_W-1:0] rsp_dat_o,
    output logic                rsp_err_o,
    output logic                stb_o,
    output logic                we_o,
    output logic [WB_ADR_W-1:0] adr_o,
    output logic [WB_SEL_W-1:0] sel_o,
    output logic [WB_DAT_W-1:0] dat_o,
    input  logic [WB_DAT_W-1:0] dat_i,
    input  logic                ack_i
);

    wb_init_state_e state_q, state_d;

    logic accept;
    logic ack_hit;
    logic to_hit;
    logic cnt_en;
    logic expired;

    assign req_ready_o = (state_q == IDLE) && rst_ni;
    assign accept      = req_valid_i && req_ready_o;
    assign ack_hit     = (state_q == BUS) && ack_i;
    assign to_hit      = (state_q == BUS) && !ack_i && expired;
    assign cnt_en      = (state_q == BUS) && !ack_i;

    wb_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr_i    (accept),
        .en_i     (cnt_en),
        .expired_o(expired)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = BUS;
            BUS:     if (ack_hit || to_hit) state_d = RESP;
            RESP:    if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus fields are left as-is after the cycle; only stb_o qualifies them.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stb_o       <= 1'b0;
            we_o        <= 1'b0;
            adr_o       <= '0;
            sel_o       <= '0;
            dat_o       <= '0;
            rsp_valid_o <= 1'b0;
            rsp_dat_o   <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            if (accept) begin
                stb_o <= 1'b1;
                we_o  <= req_we_i;
                adr_o <= req_adr_i;
                sel_o <= req_sel_i;
                dat_o <= req_dat_i;
            end
            if (ack_hit) begin
                stb_o       <= 1'b0;
                rsp_valid_o <= 1'b1;
                rsp_err_o   <= 1'b0;
                rsp_dat_o   <= we_o ? '0 : dat_i;
            end else if (to_hit) begin
                stb_o       <= 1'b0;
                rsp_valid_o <= 1'b1;
                rsp_err_o   <= 1'b1;
                rsp_dat_o   <= WB_ERR_DATA;
            end
            if ((state_q == RESP) && rsp_ready_i) begin
                rsp_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_initiator.sv
// Randomised self-checking bench for wb_initiator with a transaction-level
// expectation model (strobe length, error flag, response data).
module tb_wb_initiator;
    import wb_pkg::*;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [29:0] req_adr;
    logic [3:0]  req_sel;
    logic [31:0] req_dat;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_dat;
    logic        stb, we;
    logic [29:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_o, dat_i;
    logic        ack;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    wb_initiator #(.TIMEOUT(TO)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_we_i   (req_we),
        .req_adr_i  (req_adr),
        .req_sel_i  (req_sel),
        .req_dat_i  (req_dat),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_dat_o  (rsp_dat),
        .rsp_err_o  (rsp_err),
        .stb_o      (stb),
        .we_o       (we),
        .adr_o      (adr),
        .sel_o      (sel),
        .dat_o      (dat_o),
        .dat_i      (dat_i),
        .ack_i      (ack)
    );

    // ack_cycle: strobe cycle on which the slave acks (0 = never).
    // hold: cycles of response backpressure, with stray acks pulsed meanwhile.
    task automatic do_transfer(input logic we_t, input logic [29:0] adr_t,
                               input logic [3:0] sel_t, input logic [31:0] dat_t,
                               input int ack_cycle, input logic [31:0] rdata,
                               input int hold, input string name);
        bit          acked;
        int          exp_len;
        logic        exp_err;
        logic [31:0] exp_dat;
        int          n;
        acked   = (ack_cycle > 0) && (ack_cycle <= int'(TO));
        exp_len = acked ? ack_cycle : int'(TO);
        exp_err = !acked;
        exp_dat = (acked && !we_t) ? rdata : 32'h0;

        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1) begin
            $display("FAIL %s idle_ready: got %b want 1", name, req_ready); miscompares++;
        end
        req_valid = 1'b1; req_we = we_t; req_adr = adr_t; req_sel = sel_t; req_dat = dat_t;
        @(negedge clk);
        req_valid = 1'b0; req_we = ~we_t; req_adr = 30'($urandom);
        req_sel = 4'($urandom); req_dat = $urandom;
        n = 0;
        while (stb === 1'b1 && n < 2 * int'(TO) + 4) begin
            n++;
            vectors++;
            if ({we, adr, sel, dat_o} !== {we_t, adr_t, sel_t, dat_t}) begin
                $display("FAIL %s bus_fields cyc%0d: got %h want %h", name, n,
                         {we, adr, sel, dat_o}, {we_t, adr_t, sel_t, dat_t});
                miscompares++;
            end
            vectors++;
            if (rsp_valid !== 1'b0) begin
                $display("FAIL %s rsp_early cyc%0d: got %b want 0", name, n, rsp_valid); miscompares++;
            end
            if (n == ack_cycle) begin ack = 1'b1; dat_i = rdata; end
            else begin ack = 1'b0; dat_i = $urandom; end
            @(negedge clk);
        end
        ack = 1'b0;
        vectors++;
        if (n !== exp_len) begin
            $display("FAIL %s stb_len: got %0d want %0d", name, n, exp_len); miscompares++;
        end
        vectors++;
        if ({rsp_valid, rsp_err, rsp_dat} !== {1'b1, exp_err, exp_dat}) begin
            $display("FAIL %s rsp: got v=%b e=%b d=%h want v=1 e=%b d=%h", name,
                     rsp_valid, rsp_err, rsp_dat, exp_err, exp_dat);
            miscompares++;
        end
        for (int i = 0; i < hold; i++) begin
            rsp_ready = 1'b0; ack = (i % 2 == 0); dat_i = $urandom;
            @(negedge clk);
            vectors++;
            if ({rsp_valid, rsp_err, rsp_dat, req_ready, stb} !== {1'b1, exp_err, exp_dat, 1'b0, 1'b0}) begin
                $display("FAIL %s hold%0d: got v=%b e=%b d=%h rdy=%b stb=%b want v=1 e=%b d=%h rdy=0 stb=0",
                         name, i, rsp_valid, rsp_err, rsp_dat, req_ready, stb, exp_err, exp_dat);
                miscompares++;
            end
        end
        ack = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        vectors++;
        if ({rsp_valid, req_ready, stb, adr} !== {1'b0, 1'b1, 1'b0, adr_t}) begin
            $display("FAIL %s release: got v=%b rdy=%b stb=%b adr=%h want v=0 rdy=1 stb=0 adr=%h",
                     name, rsp_valid, req_ready, stb, adr, adr_t);
            miscompares++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_adr = '0; req_sel = '0;
        req_dat = '0; rsp_ready = 1'b0; dat_i = '0; ack = 1'b0;
        #12;
        vectors++;
        if ({stb, we, adr, sel, dat_o, rsp_valid, rsp_dat, rsp_err, req_ready} !== '0) begin
            $display("FAIL reset_values: got stb=%b we=%b adr=%h sel=%h dat=%h v=%b rd=%h e=%b rdy=%b want all 0",
                     stb, we, adr, sel, dat_o, rsp_valid, rsp_dat, rsp_err, req_ready);
            miscompares++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 1'b1) begin
            $display("FAIL reset_release_ready: got %b want 1", req_ready); miscompares++;
        end
    endtask

    task automatic test_write_zero_wait();
        do_transfer(1'b1, 30'h0000_0010, 4'hF, 32'hCAFE_F00D, 1, 32'hDEAD_BEEF, 0, "write_zw");
    endtask

    task automatic test_read_wait_states();
        do_transfer(1'b0, 30'h4, 4'hF, 32'h0, 4, 32'h1234_5678, 0, "read_3ws");
    endtask

    task automatic test_timeout();
        do_transfer(1'b0, 30'h20, 4'h3, 32'h0, 0, 32'hAAAA_5555, 0, "timeout");
        do_transfer(1'b0, 30'h24, 4'hC, 32'h0, int'(TO), 32'h0BAD_F00D, 0, "ack_last");
    endtask

    task automatic test_backpressure();
        do_transfer(1'b0, 30'h3F, 4'h5, 32'h0, 2, 32'h5A5A_A5A5, 5, "backpressure");
    endtask

    task automatic test_reset_mid_bus();
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_adr = 30'h77; req_sel = 4'hF; req_dat = '0;
        @(negedge clk);
        req_valid = 1'b0; ack = 1'b0;
        @(negedge clk);
        vectors++;
        if (stb !== 1'b1) begin
            $display("FAIL midbus_stb_cyc2: got %b want 1", stb); miscompares++;
        end
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if ({stb, rsp_valid, req_ready} !== 3'b000) begin
            $display("FAIL midbus_async: got stb=%b v=%b rdy=%b want 000", stb, rsp_valid, req_ready);
            miscompares++;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({stb, rsp_valid, req_ready} !== 3'b001) begin
            $display("FAIL midbus_after: got stb=%b v=%b rdy=%b want 001", stb, rsp_valid, req_ready);
            miscompares++;
        end
        do_transfer(1'b1, 30'h1_2345, 4'hA, 32'h0F0F_1234, 1, 32'h0, 1, "post_reset_write");
    endtask

    task automatic test_back_to_back();
        int stb_cnt = 0;
        int rsp_cnt = 0;
        @(negedge clk);
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_adr = 30'h100; req_sel = 4'hF; req_dat = 32'h1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (stb === 1'b1) stb_cnt++;
            if (rsp_valid === 1'b1) rsp_cnt++;
            ack = stb; dat_i = $urandom;
            if (i == 12) begin req_valid = 1'b0; ack = 1'b0; end
        end
        rsp_ready = 1'b0;
        vectors++;
        if (stb_cnt !== 4 || rsp_cnt !== 4) begin
            $display("FAIL back_to_back: got stb=%0d rsp=%0d want 4 4", stb_cnt, rsp_cnt); miscompares++;
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 24; t++) begin
            logic [3:0] s;
            s = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            do_transfer(1'($urandom), 30'($urandom), s, $urandom,
                        int'($urandom_range(0, TO + 2)), $urandom,
                        int'($urandom_range(0, 3)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_wait_states();
        test_timeout();
        test_backpressure();
        test_reset_mid_bus();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
